// File: rtl/cache_data_array.sv
// Set-associative cache data store: word read/write, burst block fill and
// handshaked block evict, sequenced by an IDLE/FILL/EVICT controller.
module cache_data_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 32,
  parameter int WORDS = 8,
  parameter int WIDTH = 16,
  localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int SETW  = $clog2(SETS),
  localparam int WORDW = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WAYW-1:0]  req_way,
  input  logic [SETW-1:0]  req_set,
  input  logic [WORDW-1:0] req_word,
  input  logic [WIDTH-1:0] wr_data,
  output logic             req_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             fill_valid,
  input  logic [WIDTH-1:0] fill_data,
  output logic             fill_done,
  output logic             evict_valid,
  output logic [WIDTH-1:0] evict_data,
  output logic             evict_last,
  input  logic             evict_ready
);

  localparam int DEPTH = WAYS * SETS * WORDS;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = WAYW + SETW + WORDW;

  typedef enum logic [1:0] {IDLE, FILL, EVICT} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WAYW-1:0]  lat_way;
  logic [SETW-1:0]  lat_set;
  logic [WORDW-1:0] cnt;
  logic             accept, last_word, wr_en;
  logic [AW-1:0]    req_addr, burst_addr, wr_addr;
  logic [WIDTH-1:0] wr_val;

  // With a single way the way field is dropped by truncation to AW bits.
  function automatic logic [AW-1:0] addr_of(input logic [WAYW-1:0] w,
                                            input logic [SETW-1:0] s,
                                            input logic [WORDW-1:0] o);
    logic [FW-1:0] full;
    full = {w, s, o};
    return full[AW-1:0];
  endfunction

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid & req_ready;
  assign last_word   = (cnt == WORDW'(WORDS - 1));
  assign req_addr    = addr_of(req_way, req_set, req_word);
  assign burst_addr  = addr_of(lat_way, lat_set, cnt);
  assign evict_valid = (state == EVICT);
  assign evict_last  = (state == EVICT) && last_word;
  assign evict_data  = mem[burst_addr];

  // Host writes only happen in IDLE and fill writes only in FILL, so one port suffices.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_addr;
    wr_val  = wr_data;
    if (accept && req_op == 2'b01) begin
      wr_en = 1'b1;
    end else if (state == FILL && fill_valid) begin
      wr_en   = 1'b1;
      wr_addr = burst_addr;
      wr_val  = fill_data;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept && req_op == 2'b10) next_state = FILL;
             else if (accept && req_op == 2'b11) next_state = EVICT;
      FILL:  if (fill_valid && last_word) next_state = IDLE;
      EVICT: if (evict_ready && last_word) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_way   <= '0;
      lat_set   <= '0;
      cnt       <= '0;
      fill_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      fill_done <= (state == FILL) && fill_valid && last_word;
      rd_valid  <= accept && (req_op == 2'b00);
      if (accept && req_op == 2'b00) rd_data <= mem[req_addr];
      if (accept && req_op[1]) begin
        lat_way <= req_way;
        lat_set <= req_set;
        cnt     <= '0;
      end else if ((state == FILL && fill_valid) || (state == EVICT && evict_ready)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_val;
    end
  end

endmodule

// File: doc/cache_data_array.md
CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 Parameter WAYS, default 4, number of ways (power of two, >=1).
REQ-002 Parameter SETS, default 32, sets per way (power of two, >=2).
REQ-003 Parameter WORDS, default 8, words per block (power of two, >=2).
REQ-004 Parameter WIDTH, default 16, bits per word.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_op  input  2  00 read word, 01 write word, 10 block fill, 11 block evict.
REQ-009 req_way  input  clog2(WAYS) (min 1)  target way.
REQ-010 req_set  input  clog2(SETS)  target set.
REQ-011 req_word  input  clog2(WORDS)  word offset; read/write only.
REQ-012 wr_data  input  WIDTH  write data; write only.
REQ-013 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-014 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-015 rd_data  output  WIDTH  registered read data.
REQ-016 fill_valid  input  1  fill_data carries next word of a fill burst.
REQ-017 fill_data  input  WIDTH  fill word.
REQ-018 fill_done  output  1  one-cycle pulse, fill burst complete.
REQ-019 evict_valid  output  1  evict_data valid.
REQ-020 evict_data  output  WIDTH  current evicted word.
REQ-021 evict_last  output  1  evict_data is word WORDS-1.
REQ-022 evict_ready  input  1  consumer accepts evict_data this cycle.

Function
REQ-023 Storage: WAYS x SETS x WORDS words of WIDTH bits; exactly one word written per cycle at most.
REQ-024 FSM states IDLE, FILL, EVICT; req_ready = 1 only in IDLE.
REQ-025 Handshake: request accepted iff req_valid & req_ready; inputs ignored otherwise.
REQ-026 Read accepted in cycle N -> rd_valid=1, rd_data=addressed word in cycle N+1; rd_data holds last value while rd_valid=0.
REQ-027 Write accepted in cycle N -> word updated at edge ending N; read accepted N+1 returns new value.
REQ-028 Fill accepted: latch way/set, word counter=0, go FILL next cycle.
REQ-029 In FILL, each cycle with fill_valid=1 writes fill_data to word[counter], counter+1; fill_valid=0 stalls, no write.
REQ-030 Write of word WORDS-1 in FILL -> next cycle IDLE, fill_done=1 for exactly that cycle; counter wraps to 0.
REQ-031 Evict accepted: latch way/set, counter=0, go EVICT next cycle.
REQ-032 In EVICT: evict_valid=1, evict_data=word[counter] (combinational from array), evict_last=(counter==WORDS-1).
REQ-033 evict_valid & evict_ready: counter+1; if evict_last, next state IDLE, evict_valid=0 next cycle; evict_ready=0 holds data stable.
REQ-034 fill_valid outside FILL and evict_ready outside EVICT have no effect.
REQ-035 Fill/evict acceptance does not pulse rd_valid; rd_valid=0 in all non-read cycles.

Reset
REQ-036 rst=0 asynchronously: state IDLE, counters 0, all storage words 0, rd_data 0, rd_valid 0, fill_done 0, evict_valid 0, evict_last 0; req_ready 1 after release.
REQ-037 Reset mid-FILL or mid-EVICT aborts the burst; no fill_done; partially written block reads 0.

Verification
REQ-038 Write way2 set5 word3 0xBEEF, read same next cycle -> rd_valid=1, rd_data=0xBEEF one cycle later; other words 0.
REQ-039 Fill way1 set7 with 0x1000..0x1007, fill_valid low 2 cycles after word 3 -> no write during stall, fill_done one pulse after word 7, 8 reads return 0x1000..0x1007.
REQ-040 Evict that block, evict_ready toggling 1,0,1 -> evict_data holds when 0, evict_last only on 0x1007, IDLE after 8 handshakes.
REQ-041 req_valid read during FILL/EVICT -> req_ready=0, no rd_valid, no state change.
REQ-042 rst low after 4 fill words -> IDLE, no fill_done, all words of way1 set7 read 0.
REQ-043 WAYS=1, WORDS=2, WIDTH=8 build: fill, evict, read/write reproduce REQ-038..040 with scaled values.
